// File: rtl/noc_pkg.sv
// Shared NOC router definitions: port geometry, port indices and arbiter state encoding.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned ADDR_W    = 3;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/nexthop_register.sv
// Write-enabled next-hop register holding the address of the packet currently routed out.
module nexthop_register #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         nhr_write_i,
  input  logic [W-1:0] nhr_address_i,
  output logic [W-1:0] nhr_q_o
);

  logic [W-1:0] nhr_q;

  always_ff @(posedge clk) begin
    if (reset)            nhr_q <= '0;
    else if (nhr_write_i) nhr_q <= nhr_address_i;
  end

  assign nhr_q_o = nhr_q;

endmodule

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping to 0.
module rr_priority_picker #(
  parameter int unsigned N    = 5,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             any_req_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output round-robin arbiter: packet-granular grant, next-hop load on grant, stall watchdog.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int unsigned ADDR_W    = noc_pkg::ADDR_W,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic                        flit_valid_i,
  input  logic                        tail_i,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic                        grant_valid_o,
  output logic                        nhr_write_o,
  output logic [ADDR_W-1:0]           nhr_address_o,
  output logic                        timeout_o
);

  localparam int unsigned PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  arb_state_t             state_q;
  logic [NUM_PORTS-1:0]   grant_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       ptr_d;
  logic [PTR_W-1:0]       win_q;
  logic [15:0]            wd_q;
  logic                   nhr_write_q;
  logic [ADDR_W-1:0]      nhr_addr_q;
  logic                   timeout_q;

  logic [NUM_PORTS-1:0]   pick_gnt;
  logic                   pick_any;
  logic [PTR_W-1:0]       pick_idx;
  logic [ADDR_W-1:0]      pick_addr;
  logic [ADDR_W-1:0]      nhr_held;
  logic                   xfer;

  rr_priority_picker #(
    .N     (NUM_PORTS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .gnt_o     (pick_gnt),
    .any_req_o (pick_any)
  );

  always_comb begin
    pick_idx  = '0;
    pick_addr = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (pick_gnt[k]) begin
        pick_idx  = pick_idx | PTR_W'(k);
        pick_addr = pick_addr | req_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    ptr_d = (win_q == PTR_W'(NUM_PORTS - 1)) ? '0 : win_q + 1'b1;
  end

  assign xfer = (state_q == LOCKED) && flit_valid_i && out_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      wd_q        <= '0;
      nhr_write_q <= 1'b0;
      nhr_addr_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      nhr_write_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q     <= LOCKED;
            grant_q     <= pick_gnt;
            win_q       <= pick_idx;
            wd_q        <= '0;
            nhr_write_q <= 1'b1;
            nhr_addr_q  <= pick_addr;
          end
        end
        LOCKED: begin
          // Tail release is checked first so a coincident watchdog expiry stays silent.
          if (xfer && tail_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_d;
          end else if (!xfer && wd_q == WD_LAST) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= ptr_d;
            timeout_q <= 1'b1;
          end else if (xfer) begin
            wd_q <= '0;
          end else if (wd_q != '1) begin
            wd_q <= wd_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  nexthop_register #(
    .W (ADDR_W)
  ) u_nhr (
    .clk           (clk),
    .reset         (reset),
    .nhr_write_i   (nhr_write_q),
    .nhr_address_i (nhr_addr_q),
    .nhr_q_o       (nhr_held)
  );

  // Between strobes the register content equals the last address driven, so reuse it as the hold value.
  assign nhr_address_o = nhr_write_q ? nhr_addr_q : nhr_held;
  assign grant_o       = grant_q;
  assign grant_valid_o = |grant_q;
  assign nhr_write_o   = nhr_write_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: vector table plus fairness and watchdog sequences.
module tb_noc_output_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  req;
  logic [14:0] req_addr;
  logic        fv, tail, rdy;

  logic [4:0]  g_a, g_b;
  logic        gv_a, gv_b, wr_a, wr_b, to_a, to_b;
  logic [2:0]  ad_a, ad_b;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  noc_output_arbiter dut (
    .clk (clk), .reset (reset), .req_i (req), .req_addr_i (req_addr),
    .flit_valid_i (fv), .tail_i (tail), .out_ready_i (rdy),
    .grant_o (g_a), .grant_valid_o (gv_a), .nhr_write_o (wr_a),
    .nhr_address_o (ad_a), .timeout_o (to_a)
  );

  noc_output_arbiter #(.TIMEOUT(8)) dut8 (
    .clk (clk), .reset (reset), .req_i (req), .req_addr_i (req_addr),
    .flit_valid_i (fv), .tail_i (tail), .out_ready_i (rdy),
    .grant_o (g_b), .grant_valid_o (gv_b), .nhr_write_o (wr_b),
    .nhr_address_o (ad_b), .timeout_o (to_b)
  );

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic       fv, tail, rdy;
    logic [4:0] g;
    logic       wr;
    logic [2:0] a;
    logic       to;
  } vec_t;

  vec_t        vecs[$];
  logic [2:0]  addr_of[5] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [4:0] q, input logic f, input logic t, input logic y);
    reset = r; req = q; fv = f; tail = t; rdy = y;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [4:0] g, input logic wr, input logic [2:0] a, input logic to);
    chk({tag, ".grant"}, 32'(g_a), 32'(g));
    chk({tag, ".gvalid"}, 32'(gv_a), 32'(|g));
    chk({tag, ".nhr_wr"}, 32'(wr_a), 32'(wr));
    chk({tag, ".nhr_addr"}, 32'(ad_a), 32'(a));
    chk({tag, ".timeout"}, 32'(to_a), 32'(to));
  endtask

  task automatic check_b(input string tag, input logic [4:0] g, input logic wr, input logic [2:0] a, input logic to);
    chk({tag, ".grant"}, 32'(g_b), 32'(g));
    chk({tag, ".gvalid"}, 32'(gv_b), 32'(|g));
    chk({tag, ".nhr_wr"}, 32'(wr_b), 32'(wr));
    chk({tag, ".nhr_addr"}, 32'(ad_b), 32'(a));
    chk({tag, ".timeout"}, 32'(to_b), 32'(to));
  endtask

  task automatic add(input logic r, input logic [4:0] q, input logic f, input logic t, input logic y,
                     input logic [4:0] g, input logic wr, input logic [2:0] a, input logic to);
    vec_t v;
    v.rst = r; v.req = q; v.fv = f; v.tail = t; v.rdy = y;
    v.g = g; v.wr = wr; v.a = a; v.to = to;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "bench time limit");
  end

  initial begin
    req_addr = {3'd7, 3'd6, 3'd5, 3'd2, 3'd1};
    drive(1'b1, 5'b0, 1'b0, 1'b0, 1'b0);

    //   rst req       fv    tail  rdy   | grant     wr    addr  to
    add(1, 5'b00000, 0, 0, 0,  5'b00000, 0, 3'd0, 0);  // reset state
    add(0, 5'b00100, 0, 0, 1,  5'b00100, 1, 3'd5, 0);  // single requester, 1-cycle grant
    add(0, 5'b00100, 1, 0, 1,  5'b00100, 0, 3'd5, 0);
    add(0, 5'b00100, 1, 0, 1,  5'b00100, 0, 3'd5, 0);
    add(0, 5'b00100, 1, 1, 1,  5'b00000, 0, 3'd5, 0);  // 3rd flit is tail
    add(0, 5'b00000, 1, 1, 1,  5'b00000, 0, 3'd5, 0);  // flit inputs ignored in IDLE
    add(0, 5'b00100, 0, 0, 1,  5'b00100, 1, 3'd5, 0);  // grant port 2 again, ptr=3
    add(1, 5'b00100, 1, 0, 1,  5'b00000, 0, 3'd0, 0);  // reset mid-packet
    add(0, 5'b10100, 0, 0, 1,  5'b00100, 1, 3'd5, 0);  // ptr back to 0 -> port 2 beats 4
    add(0, 5'b10100, 1, 1, 1,  5'b00000, 0, 3'd5, 0);
    add(0, 5'b01000, 0, 0, 1,  5'b01000, 1, 3'd6, 0);  // port 3, then backpressure
    for (int i = 0; i < 10; i++)
      add(0, 5'b01000, 1, 1, 0,  5'b01000, 0, 3'd6, 0);
    add(0, 5'b01000, 1, 1, 1,  5'b00000, 0, 3'd6, 0);  // credit returns -> release, ptr=4
    add(0, 5'b00011, 0, 0, 1,  5'b00001, 1, 3'd1, 0);  // wrap 4 -> 0
    add(0, 5'b00011, 1, 1, 1,  5'b00000, 0, 3'd1, 0);  // single-flit packet, ptr=1
    add(0, 5'b00011, 0, 0, 1,  5'b00010, 1, 3'd2, 0);
    add(0, 5'b00011, 1, 1, 1,  5'b00000, 0, 3'd2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].fv, vecs[i].tail, vecs[i].rdy);
      step();
      check_a($sformatf("vec%0d", i), vecs[i].g, vecs[i].wr, vecs[i].a, vecs[i].to);
    end

    // Round-robin fairness with single-flit packets from all ports.
    drive(1'b1, 5'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'b11111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_a($sformatf("rr%0d_grant", i), 5'(1 << (i % 5)), 1'b1, addr_of[i % 5], 1'b0);
      step();
      check_a($sformatf("rr%0d_idle", i), 5'b0, 1'b0, addr_of[i % 5], 1'b0);
    end

    // Watchdog on the TIMEOUT=8 instance.
    drive(1'b1, 5'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'b01000, 1'b0, 1'b0, 1'b1);
    step();
    check_b("wd_grant", 5'b01000, 1'b1, 3'd6, 1'b0);
    req = 5'b11000;
    for (int c = 1; c < 8; c++) begin
      step();
      check_b($sformatf("wd_hold%0d", c), 5'b01000, 1'b0, 3'd6, 1'b0);
    end
    step();
    check_b("wd_expire", 5'b00000, 1'b0, 3'd6, 1'b1);
    step();
    check_b("wd_next_port4", 5'b10000, 1'b1, 3'd7, 1'b0);
    drive(1'b0, 5'b01000, 1'b1, 1'b1, 1'b1);
    step();
    check_b("wd_p4_release", 5'b00000, 1'b0, 3'd7, 1'b0);

    // Tail transfer in the same cycle the watchdog would expire.
    drive(1'b0, 5'b01000, 1'b0, 1'b0, 1'b1);
    step();
    check_b("co_grant", 5'b01000, 1'b1, 3'd6, 1'b0);
    for (int c = 1; c < 8; c++) begin
      step();
      check_b($sformatf("co_hold%0d", c), 5'b01000, 1'b0, 3'd6, 1'b0);
    end
    drive(1'b0, 5'b00000, 1'b1, 1'b1, 1'b1);
    step();
    check_b("co_tail_wins", 5'b00000, 1'b0, 3'd6, 1'b0);
    drive(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
    step();
    check_b("co_quiet", 5'b00000, 1'b0, 3'd6, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
